// File: rtl/fx_bus_arb.sv
// fx_bus_arb: two-master round-robin arbiter and sequencer for the fx bus.
// One single-beat transaction at a time; read data captured after RD_LAT.
module fx_bus_arb #(
    parameter int AW     = 22,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] fx_waddr,
    output logic          fx_wr,
    output logic [DW-1:0] fx_data,
    output logic [AW-1:0] fx_raddr,
    output logic          fx_rd,
    input  logic [DW-1:0] fx_q,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RWAIT,
        DONE
    } state_e;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          fx_wr_q, fx_wr_d;
    logic          fx_rd_q, fx_rd_d;
    logic [AW-1:0] fx_waddr_q, fx_waddr_d;
    logic [AW-1:0] fx_raddr_q, fx_raddr_d;
    logic [DW-1:0] fx_data_q, fx_data_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          gnt;

    // Next state, round-robin grant, payload latch and read-data capture
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        gnt     = rr_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt     = (m0_req && m1_req) ? rr_q : m1_req;
                    owner_d = gnt;
                    rr_d    = ~gnt;
                    addr_d  = gnt ? m1_addr : m0_addr;
                    wdata_d = gnt ? m1_wdata : m0_wdata;
                    state_d = (gnt ? m1_wr : m0_wr) ? WRITE : READ;
                end
            end
            WRITE: state_d = DONE;
            READ: begin
                cnt_d   = LAT;
                state_d = RWAIT;
            end
            RWAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q) begin
                        rd1_d = fx_q;
                    end else begin
                        rd0_d = fx_q;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of what the entered state drives
    always_comb begin
        fx_wr_d    = (state_d == WRITE);
        fx_rd_d    = (state_d == READ);
        fx_waddr_d = fx_wr_d ? addr_d : fx_waddr_q;
        fx_data_d  = fx_wr_d ? wdata_d : fx_data_q;
        fx_raddr_d = fx_rd_d ? addr_d : fx_raddr_q;
        ack0_d     = (state_d == DONE) && !owner_d;
        ack1_d     = (state_d == DONE) && owner_d;
        busy_d     = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= 1'b0;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_raddr_q <= '0;
            fx_data_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            fx_wr_q    <= fx_wr_d;
            fx_rd_q    <= fx_rd_d;
            fx_waddr_q <= fx_waddr_d;
            fx_raddr_q <= fx_raddr_d;
            fx_data_q  <= fx_data_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign fx_wr    = fx_wr_q;
    assign fx_rd    = fx_rd_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_raddr = fx_raddr_q;
    assign fx_data  = fx_data_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rd0_q;
    assign m1_rdata = rd1_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// tb_fx_bus_arb: scoreboard bench for fx_bus_arb.
// Instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_fx_bus_arb;

    localparam int AW    = 22;
    localparam int DW    = 8;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk_sys = 1'b0;
    logic rst;
    int   cyc = 0;

    logic          req   [2][2];
    logic          wr    [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wd    [2][2];
    logic          ack   [2][2];
    logic [DW-1:0] rdata [2][2];
    logic [AW-1:0] fx_waddr [2];
    logic [AW-1:0] fx_raddr [2];
    logic [DW-1:0] fx_data  [2];
    logic [DW-1:0] fx_q     [2];
    logic          fx_wr    [2];
    logic          fx_rd    [2];
    logic          busy     [2];
    logic          owner    [2];

    typedef struct {
        int            d;
        int            c;
        bit            m;
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] dt;
    } exp_t;

    exp_t bq[$];
    exp_t aq[$];
    int   errs = 0;
    int   checks = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    fx_bus_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT_A)) u_a (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(req[0][0]), .m0_wr(wr[0][0]), .m0_addr(addr[0][0]),
        .m0_wdata(wd[0][0]), .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_wr(wr[0][1]), .m1_addr(addr[0][1]),
        .m1_wdata(wd[0][1]), .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
        .fx_waddr(fx_waddr[0]), .fx_wr(fx_wr[0]), .fx_data(fx_data[0]),
        .fx_raddr(fx_raddr[0]), .fx_rd(fx_rd[0]), .fx_q(fx_q[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    fx_bus_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT_B)) u_b (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(req[1][0]), .m0_wr(wr[1][0]), .m0_addr(addr[1][0]),
        .m0_wdata(wd[1][0]), .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_wr(wr[1][1]), .m1_addr(addr[1][1]),
        .m1_wdata(wd[1][1]), .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
        .fx_waddr(fx_waddr[1]), .fx_wr(fx_wr[1]), .fx_data(fx_data[1]),
        .fx_raddr(fx_raddr[1]), .fx_rd(fx_rd[1]), .fx_q(fx_q[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    initial begin
        assert (LAT_A >= 1 && LAT_A <= 7) else $error("RD_LAT out of range");
        assert (LAT_B >= 1 && LAT_B <= 7) else $error("RD_LAT out of range");
    end

    // Slave model: dev 1 returns offset low byte, dev 2 its id, else 0
    function automatic logic [7:0] resp(input logic [AW-1:0] a);
        case (a[21:16])
            6'h01:   return a[7:0];
            6'h02:   return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    logic [8:0] pa = 9'd0;
    logic [8:0] pb [3] = '{9'd0, 9'd0, 9'd0};

    // Read pipelines; 0xEE is driven whenever no response is due
    always @(posedge clk_sys) begin
        pa    <= {fx_rd[0], resp(fx_raddr[0])};
        pb[0] <= {fx_rd[1], resp(fx_raddr[1])};
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign fx_q[0] = pa[8] ? pa[7:0] : 8'hEE;
    assign fx_q[1] = pb[2][8] ? pb[2][7:0] : 8'hEE;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: got event expected none (t=%0t)", nm, $time);
    endtask

    task automatic push_bus(input int d, input int c, input bit m, input bit rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] dt);
        bq.push_back('{d, c, m, rd, a, dt});
    endtask

    task automatic push_ack(input int d, input int c, input bit m, input bit rd,
                            input logic [DW-1:0] dt);
        aq.push_back('{d, c, m, rd, '0, dt});
    endtask

    // Monitor: compares every strobe and ack against the queued expectation
    always @(negedge clk_sys) begin : mon
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (fx_wr[d] && fx_rd[d]) fail("strobe_both");
                if (fx_wr[d] || fx_rd[d]) begin
                    if (bq.size() == 0) begin
                        fail("bus_unexpected");
                    end else begin
                        e = bq.pop_front();
                        chk("bus_dut", d, e.d);
                        chk("bus_cyc", cyc, e.c);
                        chk("bus_rd", fx_rd[d], e.rd);
                        chk("bus_owner", owner[d], e.m);
                        chk("bus_busy", busy[d], 1);
                        if (e.rd) begin
                            chk("bus_raddr", fx_raddr[d], e.a);
                        end else begin
                            chk("bus_waddr", fx_waddr[d], e.a);
                            chk("bus_wdata", fx_data[d], e.dt);
                        end
                    end
                end
                if (ack[d][0] && ack[d][1]) fail("ack_both");
                if (ack[d][0] || ack[d][1]) begin
                    if (aq.size() == 0) begin
                        fail("ack_unexpected");
                    end else begin
                        e = aq.pop_front();
                        chk("ack_dut", d, e.d);
                        chk("ack_cyc", cyc, e.c);
                        chk("ack_master", ack[d][1], e.m);
                        chk("ack_owner", owner[d], e.m);
                        chk("ack_busy", busy[d], 1);
                        if (e.rd) chk("ack_rdata", rdata[d][e.m], e.dt);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic issue(input int d, input int m, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] dt);
        req[d][m]  = 1'b1;
        wr[d][m]   = w;
        addr[d][m] = a;
        wd[d][m]   = dt;
    endtask

    // Waits for ack, then drops req on the edge that samples it
    task automatic wait_ack(input int d, input int m);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk_sys);
            got = ack[d][m];
        end
        if (!got) fail("ack_timeout");
        @(posedge clk_sys);
        #1;
        req[d][m] = 1'b0;
    endtask

    task automatic check_zero(input int d);
        chk("rst_busy", busy[d], 0);
        chk("rst_owner", owner[d], 0);
        chk("rst_ack0", ack[d][0], 0);
        chk("rst_ack1", ack[d][1], 0);
        chk("rst_fx_wr", fx_wr[d], 0);
        chk("rst_fx_rd", fx_rd[d], 0);
        chk("rst_waddr", fx_waddr[d], 0);
        chk("rst_wdata", fx_data[d], 0);
        chk("rst_raddr", fx_raddr[d], 0);
        chk("rst_rdata0", rdata[d][0], 0);
        chk("rst_rdata1", rdata[d][1], 0);
    endtask

    initial begin
        int t;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                req[d][m]  = 1'b0;
                wr[d][m]   = 1'b0;
                addr[d][m] = '0;
                wd[d][m]   = '0;
            end
        end
        #1 rst = 1'b1;
        #2;
        check_zero(0);
        check_zero(1);
        step();
        step();
        rst = 1'b0;

        // Contention from reset: m0 first, then m1
        step();
        t = cyc;
        issue(0, 0, 1, 22'h010080, 8'h5A);
        issue(0, 1, 1, 22'h030004, 8'hC3);
        push_bus(0, t + 1, 0, 0, 22'h010080, 8'h5A);
        push_ack(0, t + 2, 0, 0, 8'h00);
        push_bus(0, t + 4, 1, 0, 22'h030004, 8'hC3);
        push_ack(0, t + 5, 1, 0, 8'h00);
        wait_ack(0, 0);
        chk("idle_gap_busy", busy[0], 0);
        wait_ack(0, 1);

        // Continuous requests alternate 0,1,0,1
        step();
        t = cyc;
        issue(0, 0, 1, 22'h010001, 8'h10);
        issue(0, 1, 1, 22'h020002, 8'h20);
        for (int k = 0; k < 4; k++) begin
            push_bus(0, t + 1 + 3 * k, k[0], 0,
                     k[0] ? 22'h020002 : 22'h010001,
                     k[0] ? 8'h20 : 8'h10);
            push_ack(0, t + 2 + 3 * k, k[0], 0, 8'h00);
        end
        repeat (12) step();
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;

        // Single read by m1, RD_LAT=1
        step();
        t = cyc;
        issue(0, 1, 0, 22'h010081, 8'h00);
        push_bus(0, t + 1, 1, 1, 22'h010081, 8'h00);
        push_ack(0, t + 3, 1, 1, 8'h81);
        wait_ack(0, 1);
        chk("m0_rdata_keep", rdata[0][0], 8'h00);

        // m0 read, then a write must leave m0_rdata alone
        step();
        t = cyc;
        issue(0, 0, 0, 22'h0100A5, 8'h00);
        push_bus(0, t + 1, 0, 1, 22'h0100A5, 8'h00);
        push_ack(0, t + 3, 0, 1, 8'hA5);
        wait_ack(0, 0);
        chk("m1_rdata_hold", rdata[0][1], 8'h81);

        // m0 drops req during WRITE; ack still arrives
        step();
        t = cyc;
        issue(0, 0, 1, 22'h01FFFF, 8'h11);
        push_bus(0, t + 1, 0, 0, 22'h01FFFF, 8'h11);
        push_ack(0, t + 2, 0, 0, 8'h00);
        step();
        req[0][0] = 1'b0;
        wait_ack(0, 0);
        chk("wr_keeps_rdata", rdata[0][0], 8'hA5);
        chk("waddr_held", fx_waddr[0], 22'h01FFFF);
        chk("wdata_held", fx_data[0], 8'h11);

        // Unmapped read returns 0
        step();
        t = cyc;
        issue(0, 0, 0, 22'h3F0010, 8'h00);
        push_bus(0, t + 1, 0, 1, 22'h3F0010, 8'h00);
        push_ack(0, t + 3, 0, 1, 8'h00);
        wait_ack(0, 0);

        // RD_LAT=3 reads; garbage before the due cycle is ignored
        step();
        t = cyc;
        issue(1, 0, 0, 22'h020000, 8'h00);
        push_bus(1, t + 1, 0, 1, 22'h020000, 8'h00);
        push_ack(1, t + 5, 0, 1, 8'h02);
        wait_ack(1, 0);
        step();
        t = cyc;
        issue(1, 1, 0, 22'h010042, 8'h00);
        push_bus(1, t + 1, 1, 1, 22'h010042, 8'h00);
        push_ack(1, t + 5, 1, 1, 8'h42);
        wait_ack(1, 1);
        chk("b_m0_rdata_keep", rdata[1][0], 8'h02);

        // Reset in RWAIT drops the read with no ack
        step();
        t = cyc;
        issue(0, 0, 0, 22'h010033, 8'h00);
        push_bus(0, t + 1, 0, 1, 22'h010033, 8'h00);
        step();
        step();
        chk("busy_pre_rst", busy[0], 1);
        #2 rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        req[0][0] = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("no_ack_after_rst", busy[0], 0);

        // First grant after reset favours m0
        t = cyc;
        issue(0, 0, 1, 22'h020010, 8'h77);
        issue(0, 1, 1, 22'h010020, 8'h88);
        push_bus(0, t + 1, 0, 0, 22'h020010, 8'h77);
        push_ack(0, t + 2, 0, 0, 8'h00);
        push_bus(0, t + 4, 1, 0, 22'h010020, 8'h88);
        push_ack(0, t + 5, 1, 0, 8'h00);
        wait_ack(0, 0);
        wait_ack(0, 1);

        // Fresh m1 request alone
        step();
        t = cyc;
        issue(0, 1, 1, 22'h02ABCD, 8'h3C);
        push_bus(0, t + 1, 1, 0, 22'h02ABCD, 8'h3C);
        push_ack(0, t + 2, 1, 0, 8'h00);
        wait_ack(0, 1);

        repeat (4) step();
        chk("bus_queue_left", bq.size(), 0);
        chk("ack_queue_left", aq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fx_bus_arb.md
Name: fx_bus_arb

Overview:
- Two-master arbiter and sequencer for the shared fx register bus (22-bit address, 8-bit data, separate write and read strobes) that feeds the per-device register banks.
- Accepts single-beat read/write requests from two masters (master 0: host-interface bridge; master 1: internal sequencer/debug engine).
- Grants round-robin and drives one fx bus transaction at a time.
- Captures the slave read data after a fixed latency and returns it with a one-cycle ack.

Parameters:
AW, 22, fx bus address width (bits [21:16] are the device id, [15:0] the register offset).
DW, 8, fx bus data width.
RD_LAT, 1, cycles from the fx_rd strobe cycle to valid fx_q; legal range 1..7.

Ports:
clk_sys  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous active-high reset.
m0_req  in  1  master 0 request; held until m0_ack.
m0_wr  in  1  master 0 direction (1 = write, 0 = read); held with req.
m0_addr  in  AW  master 0 address; held with req.
m0_wdata  in  DW  master 0 write data; held with req.
m0_ack  out  1  one-cycle completion pulse to master 0.
m0_rdata  out  DW  master 0 read data; valid while m0_ack is high, held afterwards.
m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1.
fx_waddr  out  AW  bus write address.
fx_wr  out  1  bus write strobe, one cycle per write.
fx_data  out  DW  bus write data.
fx_raddr  out  AW  bus read address.
fx_rd  out  1  bus read strobe, one cycle per read.
fx_q  in  DW  OR-combined registered slave read data (0 when no slave is selected).
busy  out  1  high whenever state is not IDLE.
owner  out  1  index of the master currently granted; meaningful while busy.

Behaviour:
- One clock, clk_sys. Reset is asynchronous and active-high on rst.
- All outputs are registered. On reset every output is 0 and internal state is:
  - state = IDLE
  - rr_ptr = 0
  - RD_LAT counter = 0
  - latched address/data = 0
- States:
  - IDLE: requests are sampled. If neither req is high, stay in IDLE. Otherwise grant:
    - one req high: grant that master;
    - both high: grant master rr_ptr.
    - On grant: latch wr/addr/wdata, set owner, set rr_ptr = the other master, then go to WRITE if wr = 1, else READ.
  - WRITE: fx_wr = 1, with fx_waddr and fx_data from the latched values. Next state is DONE.
  - READ: fx_rd = 1, with fx_raddr from the latched value. Load counter = RD_LAT. Next state is RWAIT.
  - RWAIT: decrement counter each cycle. In the cycle where the counter equals 1, capture fx_q into the owner's rdata register and go to DONE.
  - DONE: owner's ack = 1 for exactly one cycle, then IDLE.
- Latency, with req first sampled high at cycle T (bus idle):
  - write: fx_wr high in T+1, ack in T+2;
  - read: fx_rd high in T+1, fx_q captured at the end of T+1+RD_LAT, ack in T+2+RD_LAT.
- Throughput: IDLE costs one cycle, so back-to-back writes from one master take 3 cycles each.
- Requester rule: deassert req on the clock edge that samples ack high. A req still high in the IDLE cycle after ack is a new request.
- Ordering: req is sampled only in IDLE. Changes to req or payload during a transaction are ignored. A req dropped mid-transaction does not abort it; the bus cycle and ack still occur.
- Address and data outputs hold their last driven value between transactions. Only the strobes return to 0.
- fx_wr and fx_rd are never high in the same cycle. Each is high for exactly one cycle per transaction.
- mN_rdata updates only on a read completion for master N. Writes and the other master's reads leave it unchanged.
- The ack of the non-owner master is always 0.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1…
- Reset asserted mid-transaction:
  - all outputs go to 0 immediately, including any strobe or ack in flight;
  - the transaction is dropped with no ack after reset release;
  - the first grant after release favours master 0.
- RD_LAT is elaborated as a constant. Values outside 1..7 are illegal; the bench checks this with an assertion.

Test Plan:
- Single write: m0 write addr 0x010080, data 0x5A, req at T -> fx_wr=1 at T+1 with fx_waddr=0x010080 and fx_data=0x5A; m0_ack at T+2; busy high T+1..T+2.
- Single read, RD_LAT=1: slave model returns 0x81 one cycle after fx_rd. m1 reads 0x010081, req at T -> fx_rd at T+1; m1_ack at T+3 with m1_rdata=0x81; m0_rdata unchanged.
- Contention: m0 and m1 both request writes at T from reset -> m0 served first (fx_wr T+1, ack T+2), then m1 (fx_wr T+4, ack T+5). Continuous requests then alternate owner 0,1,0,1.
- Latency sweep: RD_LAT=3, read of 0x020000, slave returns dev_id 0x02 -> fx_rd at T+1, capture at the end of T+4, ack at T+5 with rdata=0x02. fx_q garbage in T+2..T+3 must not be captured.
- Reset mid-read: assert rst during RWAIT -> fx_rd, acks and busy go to 0 asynchronously; no ack after release. A fresh m1 request then completes normally with owner=1.
- Protocol checks: m0 drops req in the WRITE cycle -> ack still pulses at T+2. An unmapped address read returns rdata=0x00 via fx_q=0.
